// File: rtl/asym_fifo_pkg.sv
// rtl/asym_fifo_pkg.sv - shared helpers and constants for the asymmetric FIFO family
package asym_fifo_pkg;

  localparam int ERR_STICKY     = 0;
  localparam int ERR_DYNAMIC    = 1;
  localparam int BYTE_MSB_FIRST = 0;
  localparam int BYTE_LSB_FIRST = 1;

  // Ceiling log2, never below 1 so that a degenerate value still yields a usable vector width.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Returns 0 for an illegal width pair so the instantiating module can reject it at elaboration.
  function automatic int ratio(input int in_width, input int out_width);
    if (out_width <= 0) return 0;
    if ((in_width % out_width) != 0) return 0;
    if (in_width < 2 * out_width) return 0;
    return in_width / out_width;
  endfunction

endpackage

// File: rtl/asymfifo_s1_unpack_if.sv
// rtl/asymfifo_s1_unpack_if.sv - push/pop handshake and status bundle of the unpacking FIFO
interface asymfifo_s1_unpack_if #(
  parameter int data_in_width  = 16,
  parameter int data_out_width = 8
);

  logic                      push_req_n;
  logic                      pop_req_n;
  logic [data_in_width-1:0]  data_in;
  logic [data_out_width-1:0] data_out;
  logic                      empty;
  logic                      almost_empty;
  logic                      half_full;
  logic                      almost_full;
  logic                      full;
  logic                      part_wd;
  logic                      error;

  modport master (
    output push_req_n, pop_req_n, data_in,
    input  data_out, empty, almost_empty, half_full, almost_full, full, part_wd, error
  );

  modport slave (
    input  push_req_n, pop_req_n, data_in,
    output data_out, empty, almost_empty, half_full, almost_full, full, part_wd, error
  );

endinterface

// File: rtl/asymfifo_ram_s1.sv
// rtl/asymfifo_ram_s1.sv - synchronous-write, asynchronous-read register file for the asymmetric FIFOs
module asymfifo_ram_s1 #(
  parameter int width  = 16,
  parameter int depth  = 8,
  parameter int addr_w = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [addr_w-1:0] i_waddr,
  input  logic [width-1:0]  i_wdata,
  input  logic [addr_w-1:0] i_raddr,
  output logic [width-1:0]  o_rdata
);

  logic [width-1:0] r_mem [depth];

  // Storage is deliberately not reset; the FIFO count guards every read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/asymfifo_s1_unpack.sv
// rtl/asymfifo_s1_unpack.sv - single-clock FIFO taking wide words and delivering narrow sub-words
module asymfifo_s1_unpack
  import asym_fifo_pkg::*;
#(
  parameter int data_in_width  = 16,
  parameter int data_out_width = 8,
  parameter int depth          = 8,
  parameter int ae_level       = 2,
  parameter int af_level       = 2,
  parameter int err_mode       = ERR_STICKY,
  parameter int byte_order     = BYTE_MSB_FIRST
) (
  input  logic                 clk,
  input  logic                 rst,
  asymfifo_s1_unpack_if.slave  bus
);

  localparam int K  = ratio(data_in_width, data_out_width);
  localparam int W  = data_out_width;
  localparam int AW = clog2(depth);
  localparam int CW = clog2(depth + 1);
  localparam int SW = clog2(K);

  localparam logic [AW-1:0] P_LAST  = AW'(depth - 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(depth);
  localparam logic [CW-1:0] C_AE    = CW'(ae_level);
  localparam logic [CW-1:0] C_HF    = CW'((depth + 1) / 2);
  localparam logic [CW-1:0] C_AF    = CW'(depth - af_level);
  localparam logic [SW-1:0] S_LAST  = SW'(K - 1);

  if (K < 2) begin : g_bad_ratio
    $error("asymfifo_s1_unpack: data_in_width must be an integer multiple (>=2) of data_out_width");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_sub_idx;
  logic          r_error;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_retire;
  logic                     w_overflow;
  logic                     w_underflow;
  logic [data_in_width-1:0] w_head;
  logic [W-1:0]             w_sub [K];

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_push      = !bus.push_req_n && !w_full;
  assign w_pop       = !bus.pop_req_n && !w_empty;
  assign w_retire    = w_pop && (r_sub_idx == S_LAST);
  assign w_overflow  = !bus.push_req_n && w_full;
  assign w_underflow = !bus.pop_req_n && w_empty;

  asymfifo_ram_s1 #(
    .width  (data_in_width),
    .depth  (depth),
    .addr_w (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push && !rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sub_idx <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        if (r_sub_idx == S_LAST) begin
          r_sub_idx <= '0;
          r_rd_ptr  <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + 1'b1;
        end else begin
          r_sub_idx <= r_sub_idx + 1'b1;
        end
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (err_mode == ERR_STICKY) r_error <= r_error | w_overflow | w_underflow;
      else                        r_error <= w_overflow | w_underflow;
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_sub
    if (byte_order == BYTE_LSB_FIRST) begin : g_lsb
      assign w_sub[j] = w_head[j*W +: W];
    end else begin : g_msb
      assign w_sub[j] = w_head[data_in_width-1-j*W -: W];
    end
  end

  assign bus.data_out     = w_empty ? '0 : w_sub[r_sub_idx];
  assign bus.empty        = w_empty;
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.half_full    = (r_count >= C_HF);
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.full         = w_full;
  assign bus.part_wd      = (r_sub_idx != '0);
  assign bus.error        = r_error;

endmodule

// File: tb/tb_asymfifo_s1_unpack.sv
// tb/tb_asymfifo_s1_unpack.sv - scoreboard bench for the unpacking asymmetric FIFO
module tb_asymfifo_s1_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  asymfifo_s1_unpack_if #(.data_in_width(16), .data_out_width(8)) bus0();
  asymfifo_s1_unpack_if #(.data_in_width(16), .data_out_width(8)) bus1();
  asymfifo_s1_unpack_if #(.data_in_width(16), .data_out_width(8)) bus2();

  asymfifo_s1_unpack #(.data_in_width(16), .data_out_width(8), .depth(8), .ae_level(2),
                       .af_level(2), .err_mode(0), .byte_order(0))
    dut0 (.clk(clk), .rst(rst0), .bus(bus0));

  asymfifo_s1_unpack #(.data_in_width(16), .data_out_width(8), .depth(8), .ae_level(2),
                       .af_level(2), .err_mode(0), .byte_order(1))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  asymfifo_s1_unpack #(.data_in_width(16), .data_out_width(8), .depth(8), .ae_level(2),
                       .af_level(2), .err_mode(1), .byte_order(0))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every accepted pop must present the next expected sub-word.
  always @(negedge clk) begin
    if (!rst0 && !bus0.pop_req_n && !bus0.empty) begin
      if (q0.size() == 0) chk("pop0_unexpected", 32'(bus0.data_out), 32'hFFFF_FFFF);
      else                chk("pop0_data", 32'(bus0.data_out), 32'(q0.pop_front()));
    end
    if (!rst1 && !bus1.pop_req_n && !bus1.empty) begin
      if (q1.size() == 0) chk("pop1_unexpected", 32'(bus1.data_out), 32'hFFFF_FFFF);
      else                chk("pop1_data", 32'(bus1.data_out), 32'(q1.pop_front()));
    end
  end

  task automatic cyc0(input logic push, input logic pop, input logic [15:0] d);
    bus0.push_req_n = !push;
    bus0.pop_req_n  = !pop;
    bus0.data_in    = d;
    @(posedge clk);
    #1;
    bus0.push_req_n = 1'b1;
    bus0.pop_req_n  = 1'b1;
  endtask

  task automatic push0(input logic [15:0] d);
    q0.push_back(d[15:8]);
    q0.push_back(d[7:0]);
    cyc0(1'b1, 1'b0, d);
  endtask

  task automatic pop0();
    cyc0(1'b0, 1'b1, 16'h0000);
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    q0.delete();
  endtask

  initial begin
    bus0.push_req_n = 1'b1; bus0.pop_req_n = 1'b1; bus0.data_in = '0;
    bus1.push_req_n = 1'b1; bus1.pop_req_n = 1'b1; bus1.data_in = '0;
    bus2.push_req_n = 1'b1; bus2.pop_req_n = 1'b1; bus2.data_in = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    chk("rst_empty",    32'(bus0.empty),        1);
    chk("rst_ae",       32'(bus0.almost_empty), 1);
    chk("rst_hf",       32'(bus0.half_full),    0);
    chk("rst_af",       32'(bus0.almost_full),  0);
    chk("rst_full",     32'(bus0.full),         0);
    chk("rst_part_wd",  32'(bus0.part_wd),      0);
    chk("rst_data_out", 32'(bus0.data_out),     0);
    chk("rst_error",    32'(bus0.error),        0);

    push0(16'hA1B2);
    chk("dflt_push_data", 32'(bus0.data_out), 32'hA1);
    chk("dflt_push_part", 32'(bus0.part_wd),  0);
    chk("dflt_push_empty", 32'(bus0.empty),   0);
    pop0();
    chk("dflt_pop1_data", 32'(bus0.data_out), 32'hB2);
    chk("dflt_pop1_part", 32'(bus0.part_wd),  1);
    pop0();
    chk("dflt_pop2_empty", 32'(bus0.empty),    1);
    chk("dflt_pop2_data",  32'(bus0.data_out), 0);
    chk("dflt_pop2_part",  32'(bus0.part_wd),  0);

    for (int k = 1; k <= 8; k++) begin
      logic [7:0] b;
      b = k[7:0];
      push0({b, b});
      chk($sformatf("fill%0d_ae", k),   32'(bus0.almost_empty), 32'(k <= 2));
      chk($sformatf("fill%0d_hf", k),   32'(bus0.half_full),    32'(k >= 4));
      chk($sformatf("fill%0d_af", k),   32'(bus0.almost_full),  32'(k >= 6));
      chk($sformatf("fill%0d_full", k), 32'(bus0.full),         32'(k == 8));
    end
    chk("fill_error_clear", 32'(bus0.error), 0);
    cyc0(1'b1, 1'b0, 16'h0909);
    chk("ovf_error", 32'(bus0.error), 1);
    chk("ovf_full",  32'(bus0.full),  1);
    repeat (16) pop0();
    chk("drain_empty",  32'(bus0.empty), 1);
    chk("drain_sticky", 32'(bus0.error), 1);
    chk("drain_sb",     32'(q0.size()),  0);

    reset0();
    push0(16'h1122);
    push0(16'h3344);
    push0(16'h5566);
    pop0();
    chk("sim_pre_part", 32'(bus0.part_wd), 1);
    q0.push_back(8'h77);
    q0.push_back(8'h88);
    cyc0(1'b1, 1'b1, 16'h7788);
    chk("sim_part",  32'(bus0.part_wd),      0);
    chk("sim_data",  32'(bus0.data_out),     32'h33);
    chk("sim_ae",    32'(bus0.almost_empty), 0);
    chk("sim_hf",    32'(bus0.half_full),    0);
    chk("sim_error", 32'(bus0.error),        0);
    repeat (6) pop0();
    chk("sim_drain_empty", 32'(bus0.empty), 1);
    chk("sim_drain_sb",    32'(q0.size()),  0);

    q0.push_back(8'h99);
    q0.push_back(8'hAA);
    cyc0(1'b1, 1'b1, 16'h99AA);
    chk("unf_empty", 32'(bus0.empty),    0);
    chk("unf_error", 32'(bus0.error),    1);
    chk("unf_data",  32'(bus0.data_out), 32'h99);
    repeat (2) pop0();
    chk("unf_drain_empty", 32'(bus0.empty), 1);

    reset0();
    push0(16'h1234);
    push0(16'h5678);
    pop0();
    chk("mid_pre_part", 32'(bus0.part_wd), 1);
    rst0 = 1'b1;
    cyc0(1'b1, 1'b0, 16'hDEAD);
    rst0 = 1'b0;
    q0.delete();
    chk("mid_empty", 32'(bus0.empty),    1);
    chk("mid_part",  32'(bus0.part_wd),  0);
    chk("mid_error", 32'(bus0.error),    0);
    chk("mid_data",  32'(bus0.data_out), 0);
    push0(16'h3344);
    chk("mid_push_data", 32'(bus0.data_out), 32'h33);
    repeat (2) pop0();
    chk("mid_final_empty", 32'(bus0.empty), 1);
    chk("mid_final_sb",    32'(q0.size()),  0);

    q1.push_back(8'hB2);
    q1.push_back(8'hA1);
    bus1.push_req_n = 1'b0;
    bus1.data_in    = 16'hA1B2;
    @(posedge clk); #1;
    bus1.push_req_n = 1'b1;
    chk("lsb_first_data", 32'(bus1.data_out), 32'hB2);
    bus1.pop_req_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus1.pop_req_n = 1'b1;
    chk("lsb_empty", 32'(bus1.empty), 1);
    chk("lsb_sb",    32'(q1.size()),  0);

    chk("dyn_pre_error", 32'(bus2.error), 0);
    bus2.pop_req_n = 1'b0;
    @(posedge clk); #1;
    bus2.pop_req_n = 1'b1;
    chk("dyn_error_set", 32'(bus2.error), 1);
    @(posedge clk); #1;
    chk("dyn_error_clear", 32'(bus2.error), 0);
    @(posedge clk); #1;
    chk("dyn_error_stays", 32'(bus2.error), 0);
    chk("dyn_empty",       32'(bus2.empty), 1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asymfifo_s1_unpack.md
Name: asymfifo_s1_unpack

Overview:
Single-clock asymmetric FIFO that accepts wide words on the push side and delivers narrow sub-words on the pop side. It is the unpacking counterpart of the packing (narrow-in, wide-out) asymmetric FIFO. It sits between a wide datapath producer and a narrow serial/byte consumer. Storage is counted in wide words; the pop side walks through the sub-words of the head word before retiring it.

Parameters:
- data_in_width, 16: push word width; must be an integer multiple (≥2×) of data_out_width.
- data_out_width, 8: pop sub-word width.
- depth, 8: storage depth in wide words, 2..256.
- ae_level, 2: almost_empty threshold in wide words, 1..depth-1.
- af_level, 2: almost_full threshold in wide words, 1..depth-1.
- err_mode, 0: 0 = sticky error, 1 = error reflects the current cycle only.
- byte_order, 0: 0 = most-significant sub-word popped first; 1 = least-significant sub-word first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_req_n  in  1  active-low push request.
- pop_req_n  in  1  active-low pop request, one sub-word per pop.
- data_in  in  data_in_width  wide word to push.
- data_out  out  data_out_width  current head sub-word.
- empty  out  1  no wide words stored.
- almost_empty  out  1  word count <= ae_level.
- half_full  out  1  word count >= (depth+1)/2.
- almost_full  out  1  word count >= depth-af_level.
- full  out  1  word count == depth.
- part_wd  out  1  head word partially consumed (sub_idx != 0).
- error  out  1  overflow or underflow flag.

Behaviour:
- Derived constant: K = data_in_width/data_out_width. State: wr_ptr, rd_ptr (log2 depth, wrap depth-1→0), count (0..depth), sub_idx (0..K-1), error register. RAM has depth entries × data_in_width and is not reset.
- Reset (rst=1 at an edge): pointers, count and sub_idx go to 0; error goes to 0. Resulting outputs: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, part_wd=0, data_out=0. Reset overrides any simultaneous push or pop; a partially consumed word is discarded.
- Push (push_req_n=0, full=0): RAM[wr_ptr] <= data_in; wr_ptr increments.
- Pop (pop_req_n=0, empty=0):
  - If sub_idx < K-1: sub_idx increments.
  - Else: sub_idx <= 0, rd_ptr increments and the word is retired.
- count update: +1 on an accepted push, -1 on a retiring pop, unchanged when both happen in the same cycle.
- Sub-word selection, with j = sub_idx:
  - byte_order=0: data_out = head[data_in_width-1-j*W -: W], where W = data_out_width.
  - byte_order=1: data_out = head[j*W +: W].
  - data_out is combinational from registered state. It is forced to 0 when empty.
- Latency: a word pushed into an empty FIFO at edge N clears empty and presents its first sub-word in the cycle after edge N. There is no same-cycle bypass.
- Flags decode registered count and sub_idx, so they update in the cycle after the causing edge.
- Overflow: push while full. The push is ignored, even if a retiring pop occurs in the same cycle; that pop still completes normally.
- Underflow: pop while empty. The pop is ignored, even if a push occurs in the same cycle; that push is accepted.
- error behaviour:
  - err_mode=0: error is set on overflow or underflow and held until rst.
  - err_mode=1: error is registered and equals 1 only in the cycle after an offending cycle.
- Flags count wide words only. A partially consumed head word still counts as stored until its last sub-word is popped.

Decomposition:
- Shared package asym_fifo_pkg holds:
  - a clog2 function and a ratio function (in_width/out_width with elaboration-time check of integer multiple ≥2);
  - ERR_STICKY=0 and ERR_DYNAMIC=1 constants;
  - BYTE_MSB_FIRST=0 and BYTE_LSB_FIRST=1 constants.
- The packing FIFO reuses the same package.
- One sub-module: asymfifo_ram_s1, a synchronous-write, asynchronous-read register file (depth × data_in_width), shared with the packing FIFO.
- Pointer, count, sub_idx and flag logic stays in the top module.

Test Plan:
- Defaults:
  - Stimulus: rst=1 then 0; push 0xA1B2; then pop ×2.
  - Response: after the push, data_out=0xA1, part_wd=0, empty=0; after pop 1, data_out=0xB2, part_wd=1; after pop 2, empty=1, data_out=0, part_wd=0.
- byte_order=1:
  - Stimulus: push 0xA1B2; pop ×2.
  - Response: popped sequence is 0xB2 then 0xA1.
- Fill and flags:
  - Stimulus: push 8 words 0x0101..0x0808; keep pushing.
  - Response: almost_empty=0 after the 3rd push; half_full=1 after the 4th; almost_full=1 after the 6th; full=1 after the 8th.
  - Response: a 9th push sets error=1 (err_mode=0) and the word is not stored; popping 16 sub-words returns 01 01 02 02 … 08 08 in order, proving pointer wrap.
- Simultaneous events:
  - Stimulus: FIFO holding 3 words with sub_idx=1; push and pop in the same cycle.
  - Response: count stays 3, sub_idx=0, new word lands at the tail.
  - Stimulus: FIFO empty; push and pop in the same cycle.
  - Response: word stored, underflow error flagged.
- err_mode=1:
  - Stimulus: pop while empty for 1 cycle, then idle.
  - Response: error=1 for exactly one cycle, then 0.
- Reset mid-word:
  - Stimulus: 2 words stored, sub_idx=1; assert rst for 1 cycle together with a push.
  - Response: empty=1, part_wd=0, error=0, push discarded; a following push of 0x3344 pops as 0x33, 0x44.
